nes_pad_reader: RTL
===================

Name: nes_pad_reader

Overview:
- Drives two real NES controllers (4021 shift registers) over the native latch/clock/data wire protocol.
- Produces the parallel, active-high button bytes that the memory controller consumes as joycon_1/joycon_2.
- Replaces the DIP-switch joycon inputs at the top level.
- Polls both pads periodically on a shared latch/clock and shifts in 8 bits per pad.

Parameters:
- POLL_CYCLES, 416667: clk cycles between frame starts (60 Hz at 25 MHz).
- LATCH_CYCLES, 300: cycles pad_latch is held high (12 us).
- HALF_CYCLES, 150: cycles per pad_clk low phase and per high phase (6 us). Must be >= 4.

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  asynchronous active-low reset
- pad_data_1  in  1  serial data from pad 1; active-low (0 = pressed)
- pad_data_2  in  1  serial data from pad 2; active-low
- pad_latch  out  1  shared latch to both pads; high = parallel load
- pad_clk  out  1  shared shift clock; the rising edge advances the pads
- joycon_1  out  8  pad 1 buttons, 1 = pressed; bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- joycon_2  out  8  pad 2 buttons, same encoding
- joy_valid  out  1  one-cycle pulse when joycon_1/joycon_2 are refreshed
- busy  out  1  high while a frame is in progress (LATCH through DONE)

Behaviour:
- Reset: asynchronous, active-low.
  - While rst=0, all outputs are 0: pad_latch, pad_clk, joycon_1, joycon_2, joy_valid, busy.
  - State = IDLE, poll_cnt = 0, bit_idx = 0, shift registers = 0, synchronizers = 1.
- Synchronizers: pad_data_n pass through 2-flop synchronizers (reset value 1). All samples read the synchronizer outputs.
- poll_cnt: free-running, counts 0..POLL_CYCLES-1 and wraps. poll_tick fires on the cycle poll_cnt = POLL_CYCLES-1.
  - The first tick after reset release occurs POLL_CYCLES cycles later.
- States:
  - IDLE: outputs low. On poll_tick -> LATCH (timer = 0).
  - LATCH: pad_latch=1, busy=1 for LATCH_CYCLES cycles -> BIT_LOW, bit_idx=0.
  - BIT_LOW: pad_latch=0, pad_clk=0 for HALF_CYCLES cycles.
    - On the last cycle, capture ~sync_n into shift bit bit_idx for each pad.
    - If bit_idx=7 -> DONE; else -> BIT_HIGH.
  - BIT_HIGH: pad_clk=1 for HALF_CYCLES cycles, then bit_idx++ and -> BIT_LOW.
  - DONE (1 cycle): joycon_n <= captured bytes, registered so they are visible with joy_valid. joy_valid=1, busy=1. Next state IDLE.
- Frame length: LATCH_CYCLES + 15*HALF_CYCLES + 1 cycles, with 7 pad_clk pulses.
  - The first bit (A) is read directly after latch, with no clock pulse.
- poll_tick while busy: dropped; no queueing.
  - If frame length >= POLL_CYCLES, frames run on every other eligible tick.
- joycon_n holds its last value between frames. It changes only in DONE.
- Unplugged pad: the data line floats or pulls high, so the byte reads 0x00 (nothing pressed).
- Reset mid-frame: outputs drop immediately. No partial byte is ever published.

Optional Feature:
- Macro PAD_DEBOUNCE_EN, defined:
  - Each pad keeps the previous frame's raw byte.
  - In DONE, joycon_n updates only if the new raw byte equals the previous raw byte. The previous raw byte is updated every frame.
  - joy_valid still pulses every DONE.
  - A change therefore appears at the end of the second consecutive matching frame. The reset value of the previous raw byte is 0x00.
- Macro undefined: joycon_n updates every frame, and there is no extra storage.

Decomposition:
- Package nes_pad_pkg contains:
  - State encoding constants: IDLE, LATCH, BIT_LOW, BIT_HIGH, DONE.
  - Button bit indices: BTN_A=0 .. BTN_RIGHT=7.
  - PAD_BITS=8.
- One natural sub-module, nes_pad_chan, instantiated twice. It holds:
  - the 2-flop synchronizer;
  - the capture shift register (bit-indexed write);
  - the optional debounce compare;
  - the output byte register.
- The top FSM and counters are shared.

Test Plan:
- Test parameters: POLL_CYCLES=200, LATCH_CYCLES=4, HALF_CYCLES=4; frame = 65 cycles.
- Timing after reset release: pad_latch rises exactly 200 cycles after release and stays high for 4 cycles. Then exactly 7 pad_clk pulses occur, each high for 4 cycles. joy_valid pulses once, 65 cycles after latch rise; busy is high for those 65 cycles.
- Button mapping: pad model 1 loaded with serial levels 0,1,1,0,1,1,1,0 (A, Start, Right pressed), pad 2 all 1 -> joycon_1=0x89, joycon_2=0x00 at joy_valid.
- Hold between frames: change pad 1 to all pressed during IDLE -> joycon_1 stays 0x89 until the next DONE, then becomes 0xFF.
- Reset mid-frame: assert rst low during BIT_HIGH with bit_idx=3 -> pad_clk, busy, joycon_1 and joycon_2 are 0 immediately. After release, a full normal frame runs after 200 cycles.
- Overlong frame: POLL_CYCLES=50 (frame 65) -> frames start every 100 cycles and no tick is queued.
- With PAD_DEBOUNCE_EN: pad 1 sends 0x01 for one frame, then 0x00 -> joycon_1 stays 0x00. Sending 0x01 for two frames -> joycon_1=0x01 after the second joy_valid.

Source files
------------

// File: rtl/nes_pad_reader_pkg.sv
// ============================================================================
// nes_pad_pkg : shared state encoding and button map for the NES pad reader.
// Rev 1.0
// ============================================================================
`default_nettype none

package nes_pad_pkg;

  localparam int PAD_BITS = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    BIT_LOW  = 3'd2,
    BIT_HIGH = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

`default_nettype wire

// File: rtl/nes_pad_reader_if.sv
// ============================================================================
// nes_pad_reader_if : pad wires plus the parallel button bus toward the core.
// Rev 1.0
// ============================================================================
`default_nettype none

interface nes_pad_reader_if;
  import nes_pad_pkg::*;

  logic                pad_data_1;
  logic                pad_data_2;
  logic                pad_latch;
  logic                pad_clk;
  logic [PAD_BITS-1:0] joycon_1;
  logic [PAD_BITS-1:0] joycon_2;
  logic                joy_valid;
  logic                busy;

  modport master (
    input  pad_data_1, pad_data_2,
    output pad_latch, pad_clk, joycon_1, joycon_2, joy_valid, busy
  );

  modport slave (
    output pad_data_1, pad_data_2,
    input  pad_latch, pad_clk, joycon_1, joycon_2, joy_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/nes_pad_reader_chan.sv
// ============================================================================
// nes_pad_chan : per-pad synchronizer, bit capture and published button byte.
// Optional macro PAD_DEBOUNCE_EN: publish only on two matching frames.
// Rev 1.0
// ============================================================================
`default_nettype none

module nes_pad_chan
  import nes_pad_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pad_data_n_i,
  input  logic                cap_en_i,
  input  logic                pub_en_i,
  input  logic [2:0]          bit_idx_i,
  output logic [PAD_BITS-1:0] joy_o
);

  logic [1:0]          sync_q;
  logic [PAD_BITS-1:0] shift_q;
  logic [PAD_BITS-1:0] shift_d;
  logic [PAD_BITS-1:0] joy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], pad_data_n_i};
  end

  // The publish strobe coincides with the last capture, so use the next value.
  always_comb begin
    shift_d = shift_q;
    if (cap_en_i) shift_d[bit_idx_i] = ~sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shift_q <= '0;
    else        shift_q <= shift_d;
  end

`ifdef PAD_DEBOUNCE_EN
  logic [PAD_BITS-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      joy_q  <= '0;
    end else if (pub_en_i) begin
      prev_q <= shift_d;
      if (shift_d == prev_q) joy_q <= shift_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        joy_q <= '0;
    else if (pub_en_i) joy_q <= shift_d;
  end
`endif

  assign joy_o = joy_q;

endmodule

`default_nettype wire

// File: rtl/nes_pad_reader.sv
// ============================================================================
// nes_pad_reader : polls two NES pads on a shared latch/clock every poll period.
// Optional macro PAD_DEBOUNCE_EN (see nes_pad_chan).
// Rev 1.0
// ============================================================================
`default_nettype none

module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int POLL_CYCLES  = 416667,
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_CYCLES  = 150
) (
  input  logic            clk,
  input  logic            rst_n,
  nes_pad_reader_if.master pad_if
);

  localparam int PW   = $clog2(POLL_CYCLES + 1);
  localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_e        state_q, state_d;
  logic [PW-1:0] poll_cnt_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          poll_tick;
  logic          cap_en;
  logic          pub_en;

  assign poll_tick = (poll_cnt_q == PW'(POLL_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         poll_cnt_q <= '0;
    else if (poll_tick) poll_cnt_q <= '0;
    else                poll_cnt_q <= poll_cnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Ticks arriving outside IDLE are ignored, never queued.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    bit_idx_d = bit_idx_q;
    cap_en    = 1'b0;
    pub_en    = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (poll_tick) state_d = LATCH;
      end
      LATCH: begin
        if (timer_q == TW'(LATCH_CYCLES - 1)) begin
          state_d   = BIT_LOW;
          timer_d   = '0;
          bit_idx_d = '0;
        end
      end
      BIT_LOW: begin
        if (timer_q == TW'(HALF_CYCLES - 1)) begin
          cap_en  = 1'b1;
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            pub_en  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BIT_HIGH;
          end
        end
      end
      BIT_HIGH: begin
        if (timer_q == TW'(HALF_CYCLES - 1)) begin
          timer_d   = '0;
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = BIT_LOW;
        end
      end
      DONE: begin
        timer_d = '0;
        state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pad_if.pad_latch = (state_q == LATCH);
  assign pad_if.pad_clk   = (state_q == BIT_HIGH);
  assign pad_if.joy_valid = (state_q == DONE);
  assign pad_if.busy      = (state_q != IDLE);

  nes_pad_chan u_chan_1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_data_n_i (pad_if.pad_data_1),
    .cap_en_i     (cap_en),
    .pub_en_i     (pub_en),
    .bit_idx_i    (bit_idx_q),
    .joy_o        (pad_if.joycon_1)
  );

  nes_pad_chan u_chan_2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .pad_data_n_i (pad_if.pad_data_2),
    .cap_en_i     (cap_en),
    .pub_en_i     (pub_en),
    .bit_idx_i    (bit_idx_q),
    .joy_o        (pad_if.joycon_2)
  );

endmodule

`default_nettype wire
